// File: rtl/prog_sequencer.sv
// Launch controller: round-robin arbitration of three program requesters onto one core,
// operand load through the data-memory side port, start/halt handshake, result readback.
module prog_sequencer #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int START_CYC   = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [2:0]  req,
    input  logic [15:0] opnd0,
    input  logic [23:0] opnd1,
    input  logic [15:0] opnd2,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [23:0] result,
    output logic        timeout,
    output logic        busy,
    output logic [1:0]  prog_sel,
    output logic        start,
    input  logic        halt,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;

    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    localparam int SCW = $clog2(START_CYC + 1);

    // Per-program memory map of the resident programs.
    function automatic logic [7:0] in_base(input logic [1:0] p);
        case (p)
            2'd1:    in_base = 8'd8;
            2'd2:    in_base = 8'd0;
            default: in_base = 8'd13;
        endcase
    endfunction

    function automatic logic [1:0] n_in(input logic [1:0] p);
        n_in = (p == 2'd2) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [7:0] out_base(input logic [1:0] p);
        case (p)
            2'd1:    out_base = 8'd10;
            2'd2:    out_base = 8'd4;
            default: out_base = 8'd15;
        endcase
    endfunction

    function automatic logic [1:0] n_out(input logic [1:0] p);
        case (p)
            2'd1:    n_out = 2'd2;
            2'd2:    n_out = 2'd3;
            default: n_out = 2'd1;
        endcase
    endfunction

    logic [2:0]     state_q, state_d;
    logic [2:0]     gnt_q, gnt_d, ack_q, ack_d;
    logic [23:0]    result_q, result_d, shift_q, shift_d;
    logic           timeout_q, timeout_d, busy_q, busy_d, start_q, start_d;
    logic           we_q, we_d, re_q, re_d;
    logic [1:0]     prog_q, prog_d, ptr_q, ptr_d, bcnt_q, bcnt_d;
    logic [7:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [15:0]    acc_q, acc_d;

    // ptr_q names the requester with highest priority on the next arbitration.
    logic [2:0]  req_rot;
    logic [1:0]  rr_off, win_idx;
    logic [2:0]  rr_sum;
    logic        win_found;
    logic [23:0] win_opnd;

    always_comb begin
        case (ptr_q)
            2'd1:    req_rot = {req[0], req[2], req[1]};
            2'd2:    req_rot = {req[1], req[0], req[2]};
            default: req_rot = req;
        endcase
    end

    assign rr_off    = req_rot[0] ? 2'd0 : (req_rot[1] ? 2'd1 : 2'd2);
    assign rr_sum    = {1'b0, ptr_q} + {1'b0, rr_off};
    assign win_idx   = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
    assign win_found = |req;
    assign win_opnd  = (win_idx == 2'd0) ? {opnd0, 8'h00} :
                       (win_idx == 2'd1) ? opnd1 : {opnd2, 8'h00};

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = 3'b000;
        result_d  = result_q;
        timeout_d = timeout_q;
        prog_d    = prog_q;
        start_d   = 1'b0;
        we_d      = 1'b0;
        re_d      = 1'b0;
        addr_d    = 8'd0;
        wdata_d   = 8'd0;
        ptr_d     = ptr_q;
        wait_d    = wait_q;
        scnt_d    = scnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_LOAD;
                    gnt_d   = 3'b001 << win_idx;
                    prog_d  = win_idx + 2'd1;
                    ptr_d   = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                    we_d    = 1'b1;
                    addr_d  = in_base(win_idx + 2'd1);
                    wdata_d = win_opnd[23:16];
                    shift_d = win_opnd << 8;
                    bcnt_d  = 2'd0;
                end
            end
            S_LOAD: begin
                if (({1'b0, bcnt_q} + 3'd1) < {1'b0, n_in(prog_q)}) begin
                    we_d    = 1'b1;
                    addr_d  = in_base(prog_q) + {6'd0, bcnt_q} + 8'd1;
                    wdata_d = shift_q[23:16];
                    shift_d = shift_q << 8;
                    bcnt_d  = bcnt_q + 2'd1;
                end else begin
                    state_d = S_START;
                    start_d = 1'b1;
                    scnt_d  = '0;
                end
            end
            S_START: begin
                // halt is deliberately not looked at here: it may be stale from the last run.
                if (scnt_q == SCW'(START_CYC - 1)) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end else begin
                    start_d = 1'b1;
                    scnt_d  = scnt_q + SCW'(1);
                end
            end
            S_WAIT: begin
                if (halt) begin
                    state_d = S_READ;
                    re_d    = 1'b1;
                    addr_d  = out_base(prog_q);
                    bcnt_d  = 2'd0;
                    acc_d   = 16'd0;
                end else if (wait_q == WCW'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_ACK;
                    ack_d     = gnt_q;
                    result_d  = 24'hFFFFFF;
                    timeout_d = 1'b1;
                    prog_d    = 2'd0;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_READ: begin
                // Byte k arrives one cycle after its read strobe, so READ spans bytes+1 cycles.
                if (bcnt_q != 2'd0) acc_d = {acc_q[7:0], mem_rdata};
                if (bcnt_q == n_out(prog_q)) begin
                    state_d   = S_ACK;
                    ack_d     = gnt_q;
                    result_d  = {acc_q, mem_rdata};
                    timeout_d = 1'b0;
                    prog_d    = 2'd0;
                end else begin
                    if (({1'b0, bcnt_q} + 3'd1) < {1'b0, n_out(prog_q)}) begin
                        re_d   = 1'b1;
                        addr_d = out_base(prog_q) + {6'd0, bcnt_q} + 8'd1;
                    end
                    bcnt_d = bcnt_q + 2'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
                prog_d  = 2'd0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= 3'b000;
            ack_q     <= 3'b000;
            result_q  <= 24'd0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            prog_q    <= 2'd0;
            start_q   <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            ptr_q     <= 2'd0;
            wait_q    <= '0;
            scnt_q    <= '0;
            bcnt_q    <= 2'd0;
            shift_q   <= 24'd0;
            acc_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            prog_q    <= prog_d;
            start_q   <= start_d;
            we_q      <= we_d;
            re_q      <= re_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ptr_q     <= ptr_d;
            wait_q    <= wait_d;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign result    = result_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;
    assign prog_sel  = prog_q;
    assign start     = start_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a behavioural core (memory + halt after W wait cycles) and a
// per-service reference built from the program memory map, cycle formula and round-robin rule.
module tb_prog_sequencer;
    localparam int TMO = 16;
    localparam int SCY = 2;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [2:0]  req;
    logic [15:0] op0;
    logic [23:0] op1;
    logic [15:0] op2;
    logic [2:0]  gnt, ack;
    logic [23:0] result;
    logic        timeout, busy, start, halt, mem_we, mem_re;
    logic [1:0]  prog_sel;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int rr_last;

    int         w_arr [3];
    logic [7:0] outb [3][3];

    // Core model state.
    logic [7:0] cmem [256];
    logic       armed = 1'b0;
    int         hcnt = 0;
    int         w_cur = 0;
    logic [7:0] rdata_r = 8'd0;

    prog_sequencer #(.TIMEOUT_CYC(TMO), .START_CYC(SCY)) dut (
        .CLK(CLK), .Reset(Reset), .req(req),
        .opnd0(op0), .opnd1(op1), .opnd2(op2),
        .gnt(gnt), .ack(ack), .result(result), .timeout(timeout),
        .busy(busy), .prog_sel(prog_sel), .start(start), .halt(halt),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    function automatic int n_in(input int p);
        return (p == 2) ? 3 : 2;
    endfunction

    function automatic int n_out(input int p);
        return (p == 1) ? 2 : ((p == 2) ? 3 : 1);
    endfunction

    function automatic logic [7:0] in_addr(input int p, input int j);
        case (p)
            1:       return 8'(8 + j);
            2:       return 8'(j);
            default: return 8'(13 + j);
        endcase
    endfunction

    function automatic logic [7:0] out_addr(input int p, input int j);
        case (p)
            1:       return 8'(10 + j);
            2:       return 8'(4 + j);
            default: return 8'(15 + j);
        endcase
    endfunction

    function automatic logic [7:0] in_byte(input int p, input int j);
        logic [23:0] t;
        case (p)
            1:       t = {op0, 8'h00};
            2:       t = op1;
            default: t = {op2, 8'h00};
        endcase
        t = t << (8 * j);
        return t[23:16];
    endfunction

    function automatic int rr_next(input logic [2:0] pend, input int last);
        int c;
        for (int k = 1; k <= 3; k++) begin
            c = (last + k) % 3;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    // Core: halt rises on the W-th cycle after start falls and then stays up (stale level).
    assign halt      = armed && (hcnt >= w_cur);
    assign mem_rdata = rdata_r;

    always @(posedge CLK) begin
        if (mem_we) cmem[mem_addr] <= mem_wdata;
        if (mem_re) rdata_r <= cmem[mem_addr];
        if (start && prog_sel != 2'd0) begin
            armed <= 1'b1;
            hcnt  <= 1;
            w_cur <= w_arr[int'(prog_sel) - 1];
            for (int j = 0; j < n_out(int'(prog_sel)); j++)
                cmem[out_addr(int'(prog_sel), j)] <= outb[int'(prog_sel) - 1][j];
        end else if (armed && hcnt < 100000) begin
            hcnt <= hcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 64'({gnt, ack, result, timeout, busy, prog_sel, start,
                      mem_we, mem_re, mem_addr, mem_wdata}), 64'd0);
    endtask

    // Follow one service of requester idx from grant to the idle cycle after ack.
    task automatic serve(input int idx);
        int          p, k, k_exp, wexp, starts, viol;
        logic        seen, tmo;
        logic [47:0] wr_obs, wr_exp;
        logic [23:0] rd_obs, rd_exp, res_exp, res_obs;
        logic [2:0]  ack_obs;
        logic        tmo_obs;
        logic [17:0] bus_at_ack;
        p = idx + 1;
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (gnt != 3'b000) begin seen = 1'b1; break; end
            @(negedge CLK);
        end
        chk("gnt_seen", 64'(seen), 64'd1);
        chk("gnt", 64'(gnt), 64'(3'b001 << idx));
        chk("load_sel_busy", 64'({prog_sel, busy}), 64'({2'(p), 1'b1}));
        k = 1; wr_obs = '0; rd_obs = '0; starts = 0; viol = 0; seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (mem_we) wr_obs = {wr_obs[31:0], mem_addr, mem_wdata};
            if (mem_re) rd_obs = {rd_obs[15:0], mem_addr};
            if (start) starts++;
            if (mem_we && mem_re) viol++;
            if (ack != 3'b000) begin seen = 1'b1; break; end
            @(negedge CLK);
            k++;
        end
        ack_obs = ack; res_obs = result; tmo_obs = timeout;
        bus_at_ack = {mem_we, mem_re, mem_addr, mem_wdata};
        req[idx] = 1'b0;

        tmo   = (w_arr[idx] > TMO);
        wexp  = tmo ? TMO : w_arr[idx];
        k_exp = n_in(p) + SCY + wexp + (tmo ? 0 : n_out(p) + 1) + 1;
        wr_exp = '0;
        for (int j = 0; j < n_in(p); j++) wr_exp = {wr_exp[31:0], in_addr(p, j), in_byte(p, j)};
        rd_exp = '0; res_exp = '0;
        if (!tmo) begin
            for (int j = 0; j < n_out(p); j++) begin
                rd_exp  = {rd_exp[15:0], out_addr(p, j)};
                res_exp = {res_exp[15:0], outb[idx][j]};
            end
        end else begin
            res_exp = 24'hFFFFFF;
        end

        chk("ack_seen", 64'(seen), 64'd1);
        chk("ack", 64'(ack_obs), 64'(3'b001 << idx));
        chk("ack_cycle", 64'(k), 64'(k_exp));
        chk("result", 64'(res_obs), 64'(res_exp));
        chk("timeout", 64'(tmo_obs), 64'(tmo));
        chk("writes", 64'(wr_obs), 64'(wr_exp));
        chk("reads", 64'(rd_obs), 64'(rd_exp));
        chk("start_cycles", 64'(starts), 64'(SCY));
        chk("we_re_overlap", 64'(viol), 64'd0);
        chk("bus_idle_at_ack", 64'(bus_at_ack), 64'd0);
        @(negedge CLK);
        chk("post_ack_idle", 64'({ack, gnt, busy}), 64'd0);
        rr_last = idx;
    endtask

    initial begin
        logic [2:0] pend;
        int         idx;
        logic       seen;
        Reset = 1'b1; req = 3'b000;
        op0 = '0; op1 = '0; op2 = '0;
        for (int i = 0; i < 3; i++) begin
            w_arr[i] = 3;
            for (int j = 0; j < 3; j++) outb[i][j] = 8'h00;
        end
        repeat (3) @(negedge CLK);
        chk_zero("reset_values");
        Reset = 1'b0;
        rr_last = 2;
        @(negedge CLK);

        // P1 nominal: halt 5 cycles after start falls.
        op0 = 16'd127; outb[0][0] = 8'h02; outb[0][1] = 8'h04; w_arr[0] = 6;
        req = 3'b001; serve(0);

        // P2 nominal.
        op1 = {16'd254, 8'd255}; outb[1][0] = 8'hFE; outb[1][1] = 8'hFF; outb[1][2] = 8'h00;
        w_arr[1] = 2;
        req = 3'b010; serve(1);

        // P3 launched while halt is still high from the P2 run.
        op2 = 16'hBEEF; outb[2][0] = 8'h5A; w_arr[2] = 5;
        req = 3'b100; serve(2);

        // Round-robin with all three held, then 011.
        w_arr[0] = 3; w_arr[1] = 4; w_arr[2] = 2;
        req = 3'b111; serve(0); serve(1); serve(2);
        req = 3'b011; serve(0); serve(1);

        // Timeout: halt never rises within the WAIT budget.
        op1 = 24'h123456; w_arr[1] = 40;
        req = 3'b010; serve(1);

        // Randomised request sets, served in round-robin order.
        for (int it = 0; it < 25; it++) begin
            op0 = 16'($urandom); op1 = 24'($urandom); op2 = 16'($urandom);
            for (int i = 0; i < 3; i++) begin
                w_arr[i] = int'($urandom_range(1, 20));
                for (int j = 0; j < 3; j++) outb[i][j] = 8'($urandom);
            end
            pend = 3'($urandom_range(1, 7));
            req = pend;
            while (pend != 3'b000) begin
                idx = rr_next(pend, rr_last);
                serve(idx);
                pend[idx] = 1'b0;
            end
        end

        // Reset in the middle of a WAIT.
        op0 = 16'($urandom); w_arr[0] = 30;
        req = 3'b001;
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (gnt != 3'b000) begin seen = 1'b1; break; end
            @(negedge CLK);
        end
        chk("rst_run_gnt", 64'({seen, gnt}), 64'({1'b1, 3'b001}));
        repeat (7) @(negedge CLK);
        chk("rst_run_busy", 64'({busy, gnt}), 64'({1'b1, 3'b001}));
        #1 Reset = 1'b1; req = 3'b100;
        #1 chk_zero("async_reset");
        @(negedge CLK);
        Reset = 1'b0;
        rr_last = 2;
        op2 = 16'h0F0F; outb[2][0] = 8'hC3; w_arr[2] = 4;
        serve(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Launch controller that shares the single program-running core among three requesters, one per resident program: 1/x reciprocal, 16/8 division and integer square root. It arbitrates round-robin, writes the winner's operand bytes into the core's data memory, pulses `start`, waits for `halt`, reads back the result bytes and returns them with a one-cycle acknowledge. It sits between the system-level requesters and the `TopLevel` core (`start`/`halt` plus a byte-wide data-memory side port).

## Interface
- `TIMEOUT_CYC`, default 4096: maximum WAIT cycles before the run is abandoned.
- `START_CYC`, default 2: cycles `start` is held high (minimum 1).

- `CLK` in 1: system clock; all logic is rising-edge.
- `Reset` in 1: asynchronous, active-high reset.
- `req` in 3: level request; bit i selects program i+1.
- `opnd0` in 16: program 1 divisor.
- `opnd1` in 24: program 2 operands; [23:8] dividend, [7:0] divisor.
- `opnd2` in 16: program 3 square-root operand.
- `gnt` out 3: one-hot; high from LOAD through ACK of the served requester.
- `ack` out 3: one-cycle pulse on the served bit at completion.
- `result` out 24: zero-extended result; valid during `ack` and held until the next `ack`.
- `timeout` out 1: qualifies `ack`; high means the run was abandoned.
- `busy` out 1: high whenever the state is not IDLE.
- `prog_sel` out 2: program index 1–3 to the core; held LOAD..READ, 0 in IDLE.
- `start` out 1: core launch.
- `halt` in 1: core done level.
- `mem_we`, `mem_re` out 1 each: data-memory write and read strobes.
- `mem_addr` out 8: data-memory byte address.
- `mem_wdata` out 8: write data.
- `mem_rdata` in 8: read data, valid the cycle after `mem_re`.

## Operation
- FSM: IDLE → LOAD → START → WAIT → READ → ACK → IDLE. On timeout the path is WAIT → ACK.
- **IDLE.** If any `req` bit is high, register the grant via round-robin and enter LOAD.
  - The search starts at the bit after the last grant. After reset the pointer gives bit 0 highest priority.
- **LOAD.** One byte written per cycle, MSB first:
  - P1: addr 8 = opnd0[15:8], addr 9 = opnd0[7:0].
  - P2: addr 0 = opnd1[23:16], addr 1 = opnd1[15:8], addr 2 = opnd1[7:0].
  - P3: addr 13 = opnd2[15:8], addr 14 = opnd2[7:0].
- **START.** `start` = 1 for `START_CYC` cycles. `halt` is ignored here because the core may still show stale `halt` from the previous run.
- **WAIT.** `start` = 0. Exit to READ on the first cycle `halt` is sampled 1.
  - A counter counts WAIT cycles. If it reaches `TIMEOUT_CYC`, go to ACK with `timeout` = 1 and `result` = 24'hFFFFFF.
- **READ.** Issue one `mem_re` per cycle, MSB first, and capture each byte one cycle later. READ lasts bytes+1 cycles.
  - P1: addrs 10, 11 → result[15:0].
  - P2: addrs 4, 5, 6 → result[23:0].
  - P3: addr 15 → result[7:0].
  - Upper result bits are 0.
- **ACK.** `ack[i]` = 1 for one cycle, then return to IDLE.
  - A `req` bit still high in IDLE counts as a new request; requesters must drop `req` on `ack`.
  - Dropping `req` mid-service does not abort the run; `ack` still pulses.
- `mem_we` and `mem_re` are never both high. Outside LOAD/READ, `mem_addr` and `mem_wdata` are 0.

## Timing
- Reset values: state IDLE, `gnt` = 0, `ack` = 0, `result` = 0, `timeout` = 0, `busy` = 0, `prog_sel` = 0, `start` = 0, `mem_we` = 0, `mem_re` = 0, `mem_addr` = 0, `mem_wdata` = 0, RR pointer = 0, WAIT counter = 0.
- Reset mid-run returns to IDLE immediately; a partial memory load is left as is.
- `req` is sampled at edge E; `gnt` and the first LOAD write appear in the cycle after E.
- Cycles from the first LOAD cycle to the `ack` cycle = bytes_in + `START_CYC` + W + bytes_out + 1 + 1, where W is the WAIT cycle count (at least 1).
  - Example, P1 with default parameters and W = 1: `ack` falls in the 9th cycle.
- Simultaneous requests are served one at a time in round-robin order. No request is granted twice while another requester is pending.
- All outputs are registered.

## Test plan
- **P1 nominal.** `req` = 001, `opnd0` = 127; core model writes 16'h0204 and raises `halt` 5 cycles after `start` falls.
  - Expect writes 8←00, 9←7F; `start` high exactly 2 cycles.
  - Expect `ack` = 001, `result` = 24'h000204, `timeout` = 0.
- **P2 nominal.** `req` = 010, `opnd1` = {16'd254, 8'd255}.
  - Expect writes 0←00, 1←FE, 2←FF.
  - Expect a read of 4/5/6 returning FE/FF/00 → `result` = 24'hFEFF00.
- **Round-robin.** `req` = 111 held, each requester dropping its `req` on its own `ack`.
  - Expect grant order 001, 010, 100.
  - Then reassert 011 → expect 001 before 010.
- **Timeout.** `TIMEOUT_CYC` = 16, `halt` held 0.
  - Expect `ack` 16 cycles after WAIT entry, with `timeout` = 1 and `result` = 24'hFFFFFF.
  - No `mem_re` is issued.
- **Stale halt.** `halt` high at launch and low during START.
  - Expect WAIT not to exit until `halt` rises again.
- **Reset mid-run.** Assert `Reset` during WAIT.
  - Expect all outputs 0 asynchronously and `busy` = 0.
  - After release, a pending `req` = 100 is granted normally.
